// File: rtl/vga_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_timing_ctrl_if
// Purpose   : configuration write/commit port of the VGA timing controller
// Revision  : 1.0
// ============================================================================
interface vga_timing_ctrl_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_addr;
  logic [10:0] cfg_data;
  logic        cfg_commit;
  logic        commit_pending;
  logic        cfg_error;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready, commit_pending, cfg_error
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready, commit_pending, cfg_error
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : programmable VGA counters/syncs with frame-aligned shadow commit
// Revision : 1.0
// ============================================================================
module vga_timing_ctrl #(
  parameter int H_DISPLAY_INIT = 1220,
  parameter int H_FP_INIT      = 31,
  parameter int H_SYNC_INIT    = 183,
  parameter int H_BP_INIT      = 92,
  parameter int V_DISPLAY_INIT = 480,
  parameter int V_FP_INIT      = 10,
  parameter int V_SYNC_INIT    = 2,
  parameter int V_BP_INIT      = 33
) (
  input  wire               clk48,
  input  wire               rst,
  vga_timing_ctrl_if.slave  cfg,
  output logic [10:0]       h_count,
  output logic [9:0]        v_count,
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              line_start,
  output logic              frame_start
);

  typedef struct packed {
    logic [10:0] hdisp;
    logic [10:0] hfp;
    logic [10:0] hsw;
    logic [10:0] hbp;
    logic [9:0]  vdisp;
    logic [9:0]  vfp;
    logic [9:0]  vsw;
    logic [9:0]  vbp;
  } timing_t;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  localparam timing_t C_INIT = '{
    hdisp: 11'(H_DISPLAY_INIT),
    hfp:   11'(H_FP_INIT),
    hsw:   11'(H_SYNC_INIT),
    hbp:   11'(H_BP_INIT),
    vdisp: 10'(V_DISPLAY_INIT),
    vfp:   10'(V_FP_INIT),
    vsw:   10'(V_SYNC_INIT),
    vbp:   10'(V_BP_INIT)
  };

  // Totals deliberately wrap at 12/11 bits.
  function automatic logic [11:0] f_htot(timing_t t);
    return {1'b0, t.hdisp} + {1'b0, t.hfp} + {1'b0, t.hsw} + {1'b0, t.hbp};
  endfunction

  function automatic logic [10:0] f_vtot(timing_t t);
    return {1'b0, t.vdisp} + {1'b0, t.vfp} + {1'b0, t.vsw} + {1'b0, t.vbp};
  endfunction

  state_t      state_q,       state_d;
  timing_t     shadow_q,      shadow_d;
  timing_t     live_q,        live_d;
  logic        error_q,       error_d;
  logic [10:0] h_count_q,     h_count_d;
  logic [9:0]  v_count_q,     v_count_d;
  logic        hsync_q,       hsync_d;
  logic        vsync_q,       vsync_d;
  logic        active_q,      active_d;
  logic        line_start_q,  line_start_d;
  logic        frame_start_q, frame_start_d;

  logic [11:0] w_live_htot;
  logic [10:0] w_live_vtot;
  logic [11:0] w_shadow_htot;
  logic [10:0] w_shadow_vtot;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_shadow_ok;
  logic [10:0] w_hval;
  logic [9:0]  w_vval;
  logic [12:0] w_hs_lo, w_hs_hi;
  logic [11:0] w_vs_lo, w_vs_hi;

  assign w_live_htot   = f_htot(live_q);
  assign w_live_vtot   = f_vtot(live_q);
  assign w_shadow_htot = f_htot(shadow_q);
  assign w_shadow_vtot = f_vtot(shadow_q);
  assign w_shadow_ok   = (w_shadow_htot <= 12'd2047) && (w_shadow_vtot <= 11'd1023);

  assign w_line_end  = ({1'b0, h_count_q} == (w_live_htot - 12'd1));
  assign w_frame_end = w_line_end && ({1'b0, v_count_q} == (w_live_vtot - 11'd1));

  // A zero field would collapse a timing region, so it is stored as 1.
  assign w_hval = (cfg.cfg_data == 11'd0) ? 11'd1 : cfg.cfg_data;
  assign w_vval = (cfg.cfg_data[9:0] == 10'd0) ? 10'd1 : cfg.cfg_data[9:0];

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    live_d    = live_q;
    error_d   = error_q;
    h_count_d = h_count_q + 11'd1;
    v_count_d = v_count_q;

    if (state_q == S_IDLE) begin
      if (cfg.cfg_valid) begin
        case (cfg.cfg_addr)
          3'd0: shadow_d.hdisp = w_hval;
          3'd1: shadow_d.hfp   = w_hval;
          3'd2: shadow_d.hsw   = w_hval;
          3'd3: shadow_d.hbp   = w_hval;
          3'd4: shadow_d.vdisp = w_vval;
          3'd5: shadow_d.vfp   = w_vval;
          3'd6: shadow_d.vsw   = w_vval;
          3'd7: shadow_d.vbp   = w_vval;
          default: shadow_d = shadow_q;
        endcase
      end
      if (cfg.cfg_commit) begin
        state_d = S_ARMED;
      end
    end else if (w_frame_end) begin
      state_d = S_IDLE;
      if (w_shadow_ok) begin
        live_d  = shadow_q;
        error_d = 1'b0;
      end else begin
        error_d = 1'b1;
      end
    end

    if (w_line_end) begin
      h_count_d = 11'd0;
      v_count_d = w_frame_end ? 10'd0 : (v_count_q + 10'd1);
    end

    // Decode the next counter values against the next live set so the
    // registered flags line up with the registered counters.
    w_hs_lo = {2'b00, live_d.hdisp} + {2'b00, live_d.hfp};
    w_hs_hi = w_hs_lo + {2'b00, live_d.hsw};
    w_vs_lo = {2'b00, live_d.vdisp} + {2'b00, live_d.vfp};
    w_vs_hi = w_vs_lo + {2'b00, live_d.vsw};

    active_d      = (h_count_d < live_d.hdisp) && (v_count_d < live_d.vdisp);
    hsync_d       = !(({2'b00, h_count_d} >= w_hs_lo) && ({2'b00, h_count_d} < w_hs_hi));
    vsync_d       = !(({2'b00, v_count_d} >= w_vs_lo) && ({2'b00, v_count_d} < w_vs_hi));
    line_start_d  = (h_count_d == 11'd0);
    frame_start_d = (h_count_d == 11'd0) && (v_count_d == 10'd0);
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      shadow_q      <= C_INIT;
      live_q        <= C_INIT;
      error_q       <= 1'b0;
      h_count_q     <= 11'd0;
      v_count_q     <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      live_q        <= live_d;
      error_q       <= error_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign cfg.commit_pending = (state_q == S_ARMED);
  assign cfg.cfg_ready      = (state_q == S_IDLE);
  assign cfg.cfg_error      = error_q;

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : scoreboard bench; a frame-arithmetic model predicts every cycle
//            of a small-timing instance and a default-timing instance
// Revision : 1.0
// ============================================================================
module tb_vga_timing_ctrl;

  typedef struct packed {
    bit [7:0][10:0] f;
    bit [7:0][10:0] s;
    bit             armed;
    bit             err;
    int             t;
  } mdl_t;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, act, ls, fs, pend, rdy, err;
  } obs_t;

  // Field order {VBP, VSYNC, VFP, VDISP, HBP, HSYNC, HFP, HDISP}
  localparam bit [7:0][10:0] INIT_D = {11'd33, 11'd2, 11'd10, 11'd480, 11'd92, 11'd183, 11'd31, 11'd1220};
  localparam bit [7:0][10:0] INIT_S = {11'd2, 11'd2, 11'd2, 11'd10, 11'd3, 11'd4, 11'd2, 11'd16};
  localparam obs_t RST_OBS = {11'd0, 10'd0, 8'b1111_1010};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  vga_timing_ctrl_if ifs();
  vga_timing_ctrl_if ifd();

  logic [10:0] h_s, h_d;
  logic [9:0]  v_s, v_d;
  logic        hs_s, vs_s, act_s, ls_s, fs_s;
  logic        hs_d, vs_d, act_d, ls_d, fs_d;

  vga_timing_ctrl #(
    .H_DISPLAY_INIT(16), .H_FP_INIT(2), .H_SYNC_INIT(4), .H_BP_INIT(3),
    .V_DISPLAY_INIT(10), .V_FP_INIT(2), .V_SYNC_INIT(2), .V_BP_INIT(2)
  ) u_small (
    .clk48(clk), .rst(rst), .cfg(ifs),
    .h_count(h_s), .v_count(v_s), .hsync(hs_s), .vsync(vs_s),
    .active(act_s), .line_start(ls_s), .frame_start(fs_s)
  );

  vga_timing_ctrl u_dflt (
    .clk48(clk), .rst(rst), .cfg(ifd),
    .h_count(h_d), .v_count(v_d), .hsync(hs_d), .vsync(vs_d),
    .active(act_d), .line_start(ls_d), .frame_start(fs_d)
  );

  obs_t got_s, got_d;
  assign got_s = {h_s, v_s, hs_s, vs_s, act_s, ls_s, fs_s, ifs.commit_pending, ifs.cfg_ready, ifs.cfg_error};
  assign got_d = {h_d, v_d, hs_d, vs_d, act_d, ls_d, fs_d, ifd.commit_pending, ifd.cfg_ready, ifd.cfg_error};

  int total = 0;
  int bad   = 0;

  function automatic int tot_h(bit [7:0][10:0] f);
    return (int'(f[0]) + int'(f[1]) + int'(f[2]) + int'(f[3])) % 4096;
  endfunction

  function automatic int tot_v(bit [7:0][10:0] f);
    return (int'(f[4]) + int'(f[5]) + int'(f[6]) + int'(f[7])) % 2048;
  endfunction

  function automatic mdl_t mdl_init(bit [7:0][10:0] init);
    mdl_t m;
    m.f = init;
    m.s = init;
    m.armed = 1'b0;
    m.err = 1'b0;
    m.t = 0;
    return m;
  endfunction

  // t counts cycles since the current frame began.
  function automatic mdl_t mdl_next(mdl_t m, bit valid, bit [2:0] addr, bit [10:0] data, bit commit);
    int flen;
    bit [10:0] val;
    flen = tot_h(m.f) * tot_v(m.f);
    val = (addr >= 3'd4) ? {1'b0, data[9:0]} : data;
    if (val == 11'd0) val = 11'd1;
    if (m.armed) begin
      if (m.t == flen - 1) begin
        if (tot_h(m.s) <= 2047 && tot_v(m.s) <= 1023) begin
          m.f = m.s;
          m.err = 1'b0;
        end else begin
          m.err = 1'b1;
        end
        m.armed = 1'b0;
      end
    end else begin
      if (valid) m.s[addr] = val;
      if (commit) m.armed = 1'b1;
    end
    m.t = (m.t == flen - 1) ? 0 : m.t + 1;
    return m;
  endfunction

  function automatic obs_t mdl_obs(mdl_t m);
    obs_t o;
    int ht, h, v, hd, hf, hw, vd, vf, vw;
    ht = tot_h(m.f);
    h  = m.t % ht;
    v  = m.t / ht;
    hd = int'(m.f[0]); hf = int'(m.f[1]); hw = int'(m.f[2]);
    vd = int'(m.f[4]); vf = int'(m.f[5]); vw = int'(m.f[6]);
    o.h    = 11'(h);
    o.v    = 10'(v);
    o.act  = (h < hd) && (v < vd);
    o.hs   = !((h >= hd + hf) && (h < hd + hf + hw));
    o.vs   = !((v >= vd + vf) && (v < vd + vf + vw));
    o.ls   = (h == 0);
    o.fs   = (m.t == 0);
    o.pend = m.armed;
    o.rdy  = !m.armed;
    o.err  = m.err;
    return o;
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(string name, obs_t got, obs_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs/vs/act/ls/fs/pend/rdy/err=%b, want h=%0d v=%0d %b",
               name, $time, got.h, got.v, got[7:0], exp.h, exp.v, exp[7:0]);
      if (bad >= 40) finish_run();
    end
  endtask

  // Scoreboard producer: sample inputs at the active edge, push prediction.
  mdl_t ms, md;
  obs_t qs[$], qd[$];

  always @(posedge clk) begin
    if (rst) begin
      ms = mdl_init(INIT_S);
      md = mdl_init(INIT_D);
      qs.push_back(RST_OBS);
      qd.push_back(RST_OBS);
    end else begin
      ms = mdl_next(ms, ifs.cfg_valid, ifs.cfg_addr, ifs.cfg_data, ifs.cfg_commit);
      md = mdl_next(md, 1'b0, 3'd0, 11'd0, 1'b0);
      qs.push_back(mdl_obs(ms));
      qd.push_back(mdl_obs(md));
    end
  end

  // Monitor: pop one prediction per cycle on the inactive edge.
  initial begin
    forever begin
      @(negedge clk);
      if (qs.size() != 0) check("small", got_s, qs.pop_front());
      if (qd.size() != 0) check("dflt", got_d, qd.pop_front());
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: run still active at %0t, want finished", $time);
    finish_run();
  end

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [2:0] a, logic [10:0] d);
    ifs.cfg_valid = 1'b1;
    ifs.cfg_addr  = a;
    ifs.cfg_data  = d;
    cyc(1);
    ifs.cfg_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    ifs.cfg_commit = 1'b1;
    cyc(1);
    ifs.cfg_commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (ifs.commit_pending && n < 6000) begin
      cyc(1);
      n++;
    end
    total++;
    if (ifs.commit_pending) begin
      bad++;
      $display("FAIL wait_idle: commit_pending=1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_small", got_s, RST_OBS);
    check("async_rst_dflt", got_d, RST_OBS);
    cyc(2);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    logic [2:0]  a;
    logic [10:0] d;
    int          n;

    rst = 1'b1;
    ifs.cfg_valid = 1'b0; ifs.cfg_addr = 3'd0; ifs.cfg_data = 11'd0; ifs.cfg_commit = 1'b0;
    ifd.cfg_valid = 1'b0; ifd.cfg_addr = 3'd0; ifd.cfg_data = 11'd0; ifd.cfg_commit = 1'b0;
    cyc(3);
    @(negedge clk);
    #1 rst = 1'b0;
    cyc(1);
    cyc(450);

    // 120-cycle line committed mid-frame
    wr(3'd0, 11'd100); wr(3'd1, 11'd4); wr(3'd2, 11'd8); wr(3'd3, 11'd8);
    cyc(37);
    pulse_commit();
    wait_idle();
    cyc(2 * 120 * 16);

    // write and second commit while armed are both dropped
    wr(3'd4, 11'd6);
    pulse_commit();
    wr(3'd0, 11'd50);
    pulse_commit();
    wait_idle();
    cyc(120 * 12 + 10);

    // horizontal total of 2100 is rejected, then a good commit clears the error
    wr(3'd0, 11'd2000); wr(3'd1, 11'd50); wr(3'd2, 11'd25); wr(3'd3, 11'd25);
    pulse_commit();
    wait_idle();
    cyc(300);
    wr(3'd0, 11'd20); wr(3'd1, 11'd2); wr(3'd2, 11'd3); wr(3'd3, 11'd3);
    pulse_commit();
    wait_idle();
    cyc(300);

    // zero vsync width is stored as one line
    wr(3'd6, 11'd0);
    pulse_commit();
    wait_idle();
    cyc(700);

    // commit plus write on the frame-end cycle wait for the following frame end
    n = 0;
    while (ms.t != tot_h(ms.f) * tot_v(ms.f) - 1 && n < 5000) begin
      cyc(1);
      n++;
    end
    ifs.cfg_valid = 1'b1; ifs.cfg_addr = 3'd7; ifs.cfg_data = 11'd4; ifs.cfg_commit = 1'b1;
    cyc(1);
    ifs.cfg_valid = 1'b0; ifs.cfg_commit = 1'b0;
    wait_idle();
    cyc(200);

    for (int it = 0; it < 14; it++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        a = 3'($urandom_range(0, 7));
        d = (a < 3'd4) ? 11'($urandom_range(0, 12))
                       : 11'($urandom_range(0, 6) | ($urandom_range(0, 1) << 10));
        wr(a, d);
      end
      cyc(int'($urandom_range(0, 60)));
      if ($urandom_range(0, 1) == 1) begin
        ifs.cfg_valid  = 1'b1;
        ifs.cfg_addr   = 3'($urandom_range(0, 3));
        ifs.cfg_data   = 11'($urandom_range(1, 12));
        ifs.cfg_commit = 1'b1;
        cyc(1);
        ifs.cfg_valid  = 1'b0;
        ifs.cfg_commit = 1'b0;
      end else begin
        pulse_commit();
      end
      if ($urandom_range(0, 2) == 0) begin
        wr(3'($urandom_range(0, 7)), 11'($urandom_range(1, 12)));
        pulse_commit();
      end
      wait_idle();
      cyc(int'($urandom_range(0, 200)));
    end

    // reset while a commit is armed, then default timing from (0,0)
    wr(3'd0, 11'd9);
    pulse_commit();
    cyc(40);
    do_reset();
    cyc(900);

    finish_run();
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Programmable VGA timing controller for the 48 MHz demo design. It generates the pixel and line counters, sync pulses and the active-video flag. Its horizontal and vertical timing fields are loaded through a small valid/ready configuration port into shadow registers. A commit request copies the shadow set into the live set on the next frame boundary, so video modes change without torn frames. Pattern and colour logic downstream consume `h_count`, `v_count` and `active` from this block.

## Interface
- `H_DISPLAY_INIT`, 1220: reset value of the live and shadow horizontal display field
- `H_FP_INIT`, 31: reset horizontal front porch
- `H_SYNC_INIT`, 183: reset horizontal sync width
- `H_BP_INIT`, 92: reset horizontal back porch
- `V_DISPLAY_INIT`, 480: reset vertical display lines
- `V_FP_INIT`, 10: reset vertical front porch
- `V_SYNC_INIT`, 2: reset vertical sync width
- `V_BP_INIT`, 33: reset vertical back porch
- `clk48`  in  1  pixel clock, 48 MHz; the only clock
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  shadow-register write request
- `cfg_ready`  out  1  write accepted this cycle when high with `cfg_valid`
- `cfg_addr`  in  3  field select: 0 HDISP, 1 HFP, 2 HSYNC, 3 HBP, 4 VDISP, 5 VFP, 6 VSYNC, 7 VBP
- `cfg_data`  in  11  field value; the V fields use bits [9:0] and ignore bit 10
- `cfg_commit`  in  1  one-cycle pulse that arms a shadow-to-live transfer
- `commit_pending`  out  1  a transfer is armed
- `cfg_error`  out  1  sticky flag: the last commit was rejected
- `h_count`  out  11  current pixel within the line
- `v_count`  out  10  current line within the frame
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `active`  out  1  high inside the display region
- `line_start`  out  1  high when `h_count` is 0
- `frame_start`  out  1  high when `h_count` and `v_count` are both 0

## Operation
- Two states: IDLE and ARMED. `commit_pending` equals (state == ARMED).
- `cfg_ready` = !`commit_pending`.
  - A write in IDLE updates the addressed shadow field.
  - A write of 0 stores 1, so every field is at least 1.
- IDLE -> ARMED when `cfg_commit` is high.
  - A write in the same cycle as `cfg_commit` is included in the commit.
  - `cfg_commit` while ARMED is ignored.
- Totals:
  - Horizontal total = HDISP+HFP+HSYNC+HBP, computed 12 bits wide.
  - Vertical total = VDISP+VFP+VSYNC+VBP, computed 11 bits wide.
- Frame end is the cycle where `h_count` = htot-1 and `v_count` = vtot-1 (live totals). At frame end in ARMED:
  - If the shadow htot ≤ 2047 and the shadow vtot ≤ 1023: live <= shadow and `cfg_error` <= 0.
  - Otherwise: live is unchanged and `cfg_error` <= 1.
  - Either way, the state returns to IDLE.
- Counters:
  - `h_count` wraps to 0 after htot-1; `v_count` increments on each wrap.
  - `v_count` wraps to 0 after vtot-1.
  - After a commit, the frame starts at (0,0) with the new live values.
- Decode from the live fields:
  - `active` = h < HDISP && v < VDISP.
  - `hsync` is low for HDISP+HFP ≤ h < HDISP+HFP+HSYNC.
  - `vsync` uses the same form on v.
- Shadow registers are never read by the counter or decode logic.

## Timing
- All outputs are registered. `hsync`, `vsync`, `active`, `line_start` and `frame_start` describe the `h_count`/`v_count` values presented in the same cycle, so decode uses next-state counter values.
- Reset values:
  - `h_count` = 0, `v_count` = 0.
  - `hsync` = 1, `vsync` = 1.
  - `active` = 1, `line_start` = 1, `frame_start` = 1.
  - `commit_pending` = 0, `cfg_error` = 0, `cfg_ready` = 1.
  - Live and shadow fields = `*_INIT`.
- Commit latency:
  - `commit_pending` rises in the cycle after the `cfg_commit` pulse.
  - The new timing is visible at the first frame_start after the next frame end.
  - A `cfg_commit` arriving on the frame-end cycle itself is applied at the following frame end.
- With the default fields, one line is 1526 cycles and one frame is 525 lines (801150 cycles).
- Reset asserted mid-frame or while ARMED: all state returns to its reset values immediately, and any pending commit and all shadow writes are discarded.

## Test plan
- Reset release with the defaults:
  - `hsync` low for exactly 183 cycles starting at h=1251.
  - Line period 1526; `vsync` low on lines 490-491; `frame_start` period 801150.
- Write HDISP=100, HFP=4, HSYNC=8, HBP=8, then commit mid-frame:
  - The current frame finishes with the old timing.
  - The next line period is 120; `hsync` is low at h=104-111; `commit_pending` falls at frame end.
- Write while ARMED:
  - `cfg_ready` = 0 and the shadow field is unchanged.
  - A second `cfg_commit` has no effect.
- Shadow horizontal fields summing to 2100, then commit:
  - At frame end the live timing is unchanged, `cfg_error` = 1 and `commit_pending` = 0.
  - A later valid commit clears `cfg_error`.
- Write VSYNC=0:
  - After commit, `vsync` is low for exactly 1 line.
- Assert `rst` while ARMED at h=700, v=300:
  - Outputs go to their reset values asynchronously.
  - After release the default timing restarts from (0,0).
